// File: rtl/line_fill_pkg.sv
// line_fill_pkg
//   Shared types and default geometry for the line fill engine.
//   LINE_WIDTH and OFS_BITS describe the default line geometry; the
//   engine recomputes them locally from its own parameters.
package line_fill_pkg;

  localparam int LF_ADDR_WIDTH     = 16;
  localparam int LF_DATA_WIDTH     = 32;
  localparam int LF_WORDS_PER_LINE = 4;

  localparam int LINE_WIDTH = LF_DATA_WIDTH * LF_WORDS_PER_LINE;
  localparam int OFS_BITS   = $clog2(LF_WORDS_PER_LINE);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_DRAIN = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_RESP     = 3'd4
  } lf_state_e;

endpackage

// File: rtl/line_fill_buf.sv
// line_fill_buf
//   One cache line of storage, organised as WORDS_PER_LINE words.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset (clears the line)
//     load_en     load the whole line from load_line (has priority)
//     load_line   full line to load
//     wr_en       write one word: wr_word into word wr_idx
//     wr_idx      word index for single-word writes
//     wr_word     data for single-word writes
//     rd_idx      word-select for the combinational read port
//     rd_word     word rd_idx of the current contents
//     line        whole line, word k at [k*DATA_WIDTH +: DATA_WIDTH]
module line_fill_buf #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int OFS_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_en,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] load_line,
  input  logic                               wr_en,
  input  logic [OFS_W-1:0]                   wr_idx,
  input  logic [DATA_WIDTH-1:0]              wr_word,
  input  logic [OFS_W-1:0]                   rd_idx,
  output logic [DATA_WIDTH-1:0]              rd_word,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] line
);

  logic [DATA_WIDTH-1:0] words [WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) words[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < WORDS_PER_LINE; i++)
        words[i] <= load_line[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (wr_en) begin
      words[wr_idx] <= wr_word;
    end
  end

  assign rd_word = words[rd_idx];

  for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_pack
    assign line[g*DATA_WIDTH +: DATA_WIDTH] = words[g];
  end

endmodule

// File: rtl/line_fill_engine.sv
// line_fill_engine
//   Converts one cache-line read or write request into a burst of
//   single-word accesses on a synchronous word-wide memory port.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     req_valid/ready     request handshake (ready only in IDLE, out of reset)
//     req_write           1 = line write, 0 = line read
//     req_addr            word address, line-offset bits ignored
//     req_wline           line to write
//     resp_valid/ready    response handshake
//     resp_rline          line buffer contents
//     mem_re/we/addr/wdata  registered memory port outputs
//     mem_rdata           memory read data, valid one cycle after mem_re
//   Build option: LINE_FILL_WRITE_RESP_EN -- when defined, writes finish
//   with a response handshake; otherwise they return straight to IDLE.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | waiting for a request
//   RD_ISSUE  | issuing read k (mem_re), capturing word k-1
//   RD_DRAIN  | capturing the last returned word
//   WR_ISSUE  | writing buffer word k (mem_we)
//   RESP      | holding resp_valid until resp_ready
module line_fill_engine
  import line_fill_pkg::*;
#(
  parameter int ADDR_WIDTH     = LF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = LF_DATA_WIDTH,
  parameter int WORDS_PER_LINE = LF_WORDS_PER_LINE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_write,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] req_wline,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] resp_rline,
  output logic                                 mem_re,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
);

  localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;
  localparam int OFS_W  = $clog2(WORDS_PER_LINE);
  localparam logic [OFS_W-1:0]      K_LAST   = OFS_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(WORDS_PER_LINE - 1);

  lf_state_e             state, state_nx;
  logic [OFS_W-1:0]      k, k_nx;
  logic [ADDR_WIDTH-1:0] base, base_nx;
  logic                  load_en;
  logic                  accept;

  // Capture pipeline: word j issued in one cycle returns in the next.
  logic                  cap_en;
  logic [OFS_W-1:0]      cap_idx;

  logic [DATA_WIDTH-1:0] buf_rd_word;
  logic [LINE_W-1:0]     buf_line;

  assign req_ready  = rst_n && (state == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == ST_RESP);
  assign resp_rline = buf_line;

  always_comb begin
    state_nx = state;
    k_nx     = k;
    base_nx  = base;
    load_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          base_nx = req_addr & ~OFS_MASK;
          k_nx    = '0;
          if (req_write) begin
            load_en  = 1'b1;
            state_nx = ST_WR_ISSUE;
          end else begin
            state_nx = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: begin
        if (k == K_LAST) begin
          k_nx     = '0;
          state_nx = ST_RD_DRAIN;
        end else begin
          k_nx = k + 1'b1;
        end
      end
      ST_RD_DRAIN: state_nx = ST_RESP;
      ST_WR_ISSUE: begin
        if (k == K_LAST) begin
          k_nx = '0;
`ifdef LINE_FILL_WRITE_RESP_EN
          state_nx = ST_RESP;
`else
          state_nx = ST_IDLE;
`endif
        end else begin
          k_nx = k + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Memory port outputs are registered from the next-state values so the
  // enables line up with the state that owns them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      base      <= '0;
      cap_en    <= 1'b0;
      cap_idx   <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      base    <= base_nx;
      cap_en  <= (state == ST_RD_ISSUE);
      cap_idx <= k;
      mem_re  <= (state_nx == ST_RD_ISSUE);
      mem_we  <= (state_nx == ST_WR_ISSUE);
      if (state_nx == ST_RD_ISSUE || state_nx == ST_WR_ISSUE)
        mem_addr <= base_nx + ADDR_WIDTH'(k_nx);
      // On accept the buffer is loaded at the same edge, so word 0 comes
      // straight from the request; later words come from the buffer.
      if (load_en)
        mem_wdata <= req_wline[DATA_WIDTH-1:0];
      else if (state_nx == ST_WR_ISSUE)
        mem_wdata <= buf_rd_word;
    end
  end

  line_fill_buf #(
    .DATA_WIDTH     (DATA_WIDTH),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .OFS_W          (OFS_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_line (req_wline),
    .wr_en     (cap_en),
    .wr_idx    (cap_idx),
    .wr_word   (mem_rdata),
    .rd_idx    (k_nx),
    .rd_word   (buf_rd_word),
    .line      (buf_line)
  );

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine with a behavioural synchronous RAM.
module tb_line_fill_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [15:0]  req_addr;
  logic [127:0] req_wline;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_rline;
  logic         mem_re;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0]  ram [0:65535];
  logic [127:0] line_a, line_w, line_top, line_hold;

  always #5 clk = ~clk;

  line_fill_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wline  (req_wline),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rline (resp_rline),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ram[16'h0040 + i] = 32'hA0 + i;
      ram[16'hFFFC + i] = 32'hF0 + i;
      ram[16'h0010 + i] = 32'h0;
      ram[16'h0000 + i] = 32'h0;
    end
    line_a    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    line_w    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    line_top  = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    mem_rdata = '0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wline  = '0;
    resp_ready = 1'b1;

    // reset held for 3 cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rline", resp_rline, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("rel_req_ready", req_ready, 1);

    // line read at 0x0042
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0042;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rd_mem_re", mem_re, 1);
      chk("rd_mem_we", mem_we, 0);
      chk("rd_mem_addr", mem_addr, 16'h0040 + i);
      chk("rd_resp_valid_early", resp_valid, 0);
      chk("rd_req_ready_busy", req_ready, 0);
      tick();
    end
    chk("rd_drain_mem_re", mem_re, 0);
    chk("rd_drain_resp_valid", resp_valid, 0);
    tick();
    chk("rd_resp_valid", resp_valid, 1);
    chk("rd_resp_rline", resp_rline, line_a);
    chk("rd_resp_req_ready", req_ready, 0);
    tick();
    chk("rd_back_idle", req_ready, 1);
    chk("rd_back_resp_valid", resp_valid, 0);

    // line write at 0x0010
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wline = line_w;
    tick();
    req_valid = 1'b0; req_wline = '0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_re", mem_re, 0);
      chk("wr_mem_addr", mem_addr, 16'h0010 + i);
      chk("wr_mem_wdata", mem_wdata, line_w[i*32 +: 32]);
      tick();
    end
    chk("wr_done_mem_we", mem_we, 0);
`ifdef LINE_FILL_WRITE_RESP_EN
    chk("wr_resp_valid", resp_valid, 1);
    chk("wr_resp_rline", resp_rline, line_w);
    chk("wr_resp_req_ready", req_ready, 0);
    tick();
    chk("wr_back_idle", req_ready, 1);
`else
    chk("wr_no_resp", resp_valid, 0);
    chk("wr_idle_ready", req_ready, 1);
`endif

    // read back the written line
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0013;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rb_resp_valid", resp_valid, 1);
    chk("rb_resp_rline", resp_rline, line_w);
    tick();

    // response backpressure
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_rline", resp_rline, line_a);
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    chk("bp_last_resp_valid", resp_valid, 1);
    tick();
    chk("bp_release_ready", req_ready, 1);
    chk("bp_release_resp_valid", resp_valid, 0);

    // reset in cycle 2 of a read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mr_cycle2_mem_re", mem_re, 1);
    rst_n = 1'b0;
    tick();
    chk("mr_mem_re_drop", mem_re, 0);
    chk("mr_resp_valid", resp_valid, 0);
    chk("mr_req_ready", req_ready, 0);
    chk("mr_rline_cleared", resp_rline, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_idle_after", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("mr_no_resp", resp_valid, 0);
      chk("mr_no_mem_re", mem_re, 0);
      tick();
    end

    // top-of-memory read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hFFFD;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("top_mem_re", mem_re, 1);
      chk("top_mem_addr", mem_addr, 16'hFFFC + i);
      tick();
    end
    chk("top_no_wrap", mem_re, 0);
    tick();
    chk("top_resp_valid", resp_valid, 1);
    chk("top_resp_rline", resp_rline, line_top);
    tick();
    chk("top_back_idle", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_fill_engine.md
# line_fill_engine

Initiator-side master for `main_memory`/`ram_sync`. It accepts one cache-line request at a time from the cache controller and converts it into a burst of single-word `re`/`we` accesses on the synchronous word-wide memory port. For reads it assembles the returned words into a line buffer; for writes it streams a supplied line out word by word. It sits between the cache controller and main memory and is the only driver of the memory's `re`, `we`, `addr` and `wdata`.

## Interface
- `ADDR_WIDTH`, 16, word-address width; matches the memory.
- `DATA_WIDTH`, 32, word width; matches the memory.
- `WORDS_PER_LINE`, 4, words per line; power of two, ≥2.
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  synchronous active-low reset, sampled on posedge `clk`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  engine can accept a request.
- `req_write`  in  1  1 = line write, 0 = line read.
- `req_addr`  in  ADDR_WIDTH  word address; low log2(WORDS_PER_LINE) bits ignored (treated as 0).
- `req_wline`  in  DATA_WIDTH*WORDS_PER_LINE  write line; word k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rline`  out  DATA_WIDTH*WORDS_PER_LINE  line buffer contents; same packing as `req_wline`.
- `mem_re`, `mem_we`  out  1  memory read/write enables.
- `mem_addr`  out  ADDR_WIDTH  memory word address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid the cycle after the `mem_re` cycle.

## Operation
- States: IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid&&req_ready`, latch base = `req_addr` with low bits cleared, and clear word counter k to 0.
  - Write: also latch `req_wline` into the line buffer, then go to WR_ISSUE. Read: go to RD_ISSUE.
- RD_ISSUE:
  - `mem_re`=1, `mem_addr`=base+k.
  - k increments each cycle. Leaves for RD_DRAIN after k=WORDS_PER_LINE-1.
- Capture: `mem_rdata` is written into buffer word j in the cycle after word j was issued. This applies in both RD_ISSUE and RD_DRAIN.
- RD_DRAIN: one cycle, no enables; captures the last word, then RESP.
- WR_ISSUE:
  - `mem_we`=1, `mem_addr`=base+k, `mem_wdata`=buffer word k.
  - Leaves after k=WORDS_PER_LINE-1 (next state set by the macro in Configuration).
- RESP:
  - `resp_valid`=1 and `resp_rline` stable until `resp_ready`.
  - When `resp_ready`=1, return to IDLE the next cycle.
  - For writes, `resp_rline` echoes the written line.
- `mem_re` and `mem_we` are never both 1.
- Address arithmetic is modulo 2^ADDR_WIDTH. Since base is aligned, a burst never wraps mid-line.
- Requests arriving outside IDLE are ignored (`req_ready`=0); the requester holds them.

## Timing
- All state, buffer and memory-port outputs are registered.
- `req_ready` is decoded from state and gated by `rst_n`.
- Reset values:
  - state=IDLE, k=0, line buffer=0.
  - `mem_re`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `resp_valid`=0, `resp_rline`=0.
  - `req_ready`=0 while `rst_n`=0, 1 in the first cycle after release.
- Cycle 0 is the accept cycle.
- Read:
  - `mem_re` high in cycles 1..N (N=WORDS_PER_LINE).
  - Words captured at the ends of cycles 2..N+1.
  - `resp_valid` first high in cycle N+2.
- Write:
  - `mem_we` high in cycles 1..N.
  - `resp_valid` high in cycle N+1.
- Back-to-back: with `resp_ready` held at 1, the next request can be accepted 1 cycle after RESP.
- Reset mid-burst:
  - The enables drop in the cycle after the reset edge.
  - The partial line is discarded and no response is produced.

## Configuration
- Macro: `LINE_FILL_WRITE_RESP_EN`.
- Defined: writes go WR_ISSUE→RESP and produce one `resp_valid` handshake, as above.
- Undefined:
  - Writes go WR_ISSUE→IDLE directly and produce no response.
  - `req_ready` is high in cycle N+1, so write-to-next-request turnaround is N+1 cycles.
  - Reads are unchanged.

## Structure
- Package `line_fill_pkg`:
  - state enum.
  - `LINE_WIDTH = DATA_WIDTH*WORDS_PER_LINE`.
  - `OFS_BITS = $clog2(WORDS_PER_LINE)`.
- Sub-module `line_fill_buf`: the line register with per-word write enable and word-select read port. Both captures and write streaming use it.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release.
  - Required: all outputs 0 during reset; `req_ready`=1 in the first cycle after release.
- Line read:
  - Stimulus: memory preloaded with word[0x40+i]=0xA0+i; read `req_addr`=0x0042.
  - Required: `mem_re` in cycles 1–4 with addrs 0x40–0x43; `resp_valid` in cycle 6 with `resp_rline`=0x000000A3_000000A2_000000A1_000000A0.
- Line write:
  - Stimulus: write `req_addr`=0x0010, `req_wline`=0x44444444_33333333_22222222_11111111.
  - Required: `mem_we` in cycles 1–4, addr 0x10 with data 0x11111111 first; a subsequent read of 0x10 returns the same line. With the macro, `resp_valid` is in cycle 5.
- Response backpressure:
  - Stimulus: hold `resp_ready`=0 for 5 cycles during RESP.
  - Required: `resp_valid` and `resp_rline` stable, `req_ready`=0 throughout; `req_ready`=1 in the cycle after `resp_ready` rises.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 in cycle 2 of a read.
  - Required: `mem_re`=0 next cycle, no `resp_valid`, IDLE after release.
- Top-of-memory read:
  - Stimulus: read `req_addr`=0xFFFD.
  - Required: addrs 0xFFFC–0xFFFF issued, no wrap to 0x0000.
